// File: rtl/uart_pkg.sv
// Shared types and constants for the parametrised UART receiver (and planned TX).
package uart_pkg;

    // Receiver frame states
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2,
        DONE,
        BREAK
    } rx_state_e;

    // Parity_Mode encodings; 3 behaves as PAR_NONE
    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_EVEN = 2'd1;
    localparam logic [1:0] PAR_ODD  = 2'd2;

    // 2-of-3 majority of three line samples
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling baud generator: prescaler of max(div_i,1) CLK cycles producing a
// tick, plus a 0..OVERSAMPLE-1 tick counter. clr_i restarts both from zero.
module uart_baud_tick #(
    parameter int unsigned DIV_W      = 16,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned CNT_W      = $clog2(OVERSAMPLE)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             tick_c_o,
    output logic [CNT_W-1:0] tick_cnt_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);

    logic [DIV_W-1:0] presc_q;
    logic [DIV_W-1:0] div_m1;
    logic [CNT_W-1:0] cnt_q;

    // A divider of 0 behaves as 1 (tick every cycle)
    assign div_m1     = (div_i == '0) ? '0 : div_i - DIV_W'(1);
    // >= keeps the prescaler from running away if the divider shrinks
    assign tick_c_o   = (presc_q >= div_m1);
    assign tick_cnt_o = cnt_q;

    // Prescaler and tick counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            cnt_q   <= '0;
        end else if (clr_i) begin
            presc_q <= '0;
            cnt_q   <= '0;
        end else if (tick_c_o) begin
            presc_q <= '0;
            cnt_q   <= (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
        end else begin
            presc_q <= presc_q + DIV_W'(1);
        end
    end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop input sync, internal oversampling baud
// generator, validated start bit, optional parity, 1/2 stop bits, break hold-off
// and a valid/ready output with parity/frame/overrun flags.
// Build option: define UART_RX_MAJORITY_VOTE_EN to take every bit as the 2-of-3
// majority of the last three tick samples instead of a single sample.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DIV_W      = 16
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              RX_Pin_In,
    input  logic              RX_En_Sig,
    input  logic [DIV_W-1:0]  Baud_Div,
    input  logic [1:0]        Parity_Mode,
    input  logic              Stop_Two,
    output logic [DATA_W-1:0] RX_Data,
    output logic              RX_Valid,
    input  logic              RX_Ready,
    output logic              Parity_Err,
    output logic              Frame_Err,
    output logic              Overrun_Err,
    output logic              Busy
);

    localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
    localparam int unsigned IDX_W = $clog2(DATA_W);

    localparam logic [CNT_W-1:0] START_PT = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_PT   = CNT_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    rx_state_e         state_q, state_d;
    logic              rx_s1_q, rx_s2_q, rx_prev_q;
    logic              tick_c;
    logic [CNT_W-1:0]  tick_cnt;
    logic              clr_c;
    logic              fall_c;
    logic              samp_start_c;
    logic              samp_bit_c;
    logic              bit_val_c;
    logic              par_en_c;
    logic              load_c;

    logic [IDX_W-1:0]  idx_q;
    logic [DATA_W-1:0] shreg_q;
    logic              par_q;
    logic              perr_q;
    logic              ferr_q;

    logic [DATA_W-1:0] data_q;
    logic              valid_q;
    logic              perr_out_q;
    logic              ferr_out_q;
    logic              ovr_q;
    logic              busy_q;

    // Line synchroniser plus one delayed copy for falling-edge detection
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_s1_q   <= RX_Pin_In;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
        end
    end

    assign fall_c       = rx_prev_q & ~rx_s2_q;
    assign samp_start_c = tick_c && (tick_cnt == START_PT);
    assign samp_bit_c   = tick_c && (tick_cnt == BIT_PT);
    assign par_en_c     = (Parity_Mode == PAR_EVEN) || (Parity_Mode == PAR_ODD);
    assign clr_c        = ((state_q == IDLE) && RX_En_Sig && fall_c) ||
                          ((state_q == START) && samp_start_c);
    assign load_c       = (state_q == DONE) && RX_En_Sig && (!valid_q || RX_Ready);

`ifdef UART_RX_MAJORITY_VOTE_EN
    logic [1:0] hist_q;

    // Line samples from the two preceding ticks for the majority vote
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            hist_q <= 2'b11;
        end else if (tick_c) begin
            hist_q <= {hist_q[0], rx_s2_q};
        end
    end

    assign bit_val_c = majority3(hist_q[1], hist_q[0], rx_s2_q);
`else
    assign bit_val_c = rx_s2_q;
`endif

    uart_baud_tick #(
        .DIV_W      (DIV_W),
        .OVERSAMPLE (OVERSAMPLE),
        .CNT_W      (CNT_W)
    ) u_baud_tick (
        .clk        (CLK),
        .rst_n      (RSTn),
        .clr_i      (clr_c),
        .div_i      (Baud_Div),
        .tick_c_o   (tick_c),
        .tick_cnt_o (tick_cnt)
    );

    // Next-state logic; disabling the receiver aborts any frame in progress
    always_comb begin
        state_d = state_q;
        if (!RX_En_Sig) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:   if (fall_c) state_d = START;
                START:  if (samp_start_c) state_d = bit_val_c ? IDLE : DATA;
                DATA:   if (samp_bit_c && (idx_q == LAST_IDX)) state_d = par_en_c ? PARITY : STOP1;
                PARITY: if (samp_bit_c) state_d = STOP1;
                STOP1:  if (samp_bit_c) state_d = Stop_Two ? STOP2 : DONE;
                STOP2:  if (samp_bit_c) state_d = DONE;
                DONE:   state_d = (ferr_q && !rx_s2_q) ? BREAK : IDLE;
                BREAK:  if (rx_s2_q) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // State register; Busy tracks the registered state
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != IDLE);
        end
    end

    // Frame datapath: bit index, shift register, running parity and error capture
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            idx_q   <= '0;
            shreg_q <= '0;
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            case (state_q)
                START: begin
                    if (samp_start_c) begin
                        idx_q  <= '0;
                        par_q  <= 1'b0;
                        perr_q <= 1'b0;
                        ferr_q <= 1'b0;
                    end
                end
                DATA: begin
                    if (samp_bit_c) begin
                        shreg_q <= {bit_val_c, shreg_q[DATA_W-1:1]};
                        par_q   <= par_q ^ bit_val_c;
                        idx_q   <= idx_q + IDX_W'(1);
                    end
                end
                PARITY: begin
                    if (samp_bit_c) begin
                        perr_q <= (bit_val_c != (par_q ^ (Parity_Mode == PAR_ODD)));
                    end
                end
                STOP1, STOP2: begin
                    if (samp_bit_c && !bit_val_c) begin
                        ferr_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Output word, flags and handshake; a DONE load wins over a same-cycle accept
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            data_q     <= '0;
            valid_q    <= 1'b0;
            perr_out_q <= 1'b0;
            ferr_out_q <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            ovr_q <= 1'b0;
            if (valid_q && RX_Ready) begin
                valid_q <= 1'b0;
            end
            if (load_c) begin
                data_q     <= shreg_q;
                perr_out_q <= perr_q;
                ferr_out_q <= ferr_q;
                valid_q    <= 1'b1;
            end else if ((state_q == DONE) && RX_En_Sig) begin
                ovr_q <= 1'b1;
            end
        end
    end

    assign RX_Data     = data_q;
    assign RX_Valid    = valid_q;
    assign Parity_Err  = perr_out_q;
    assign Frame_Err   = ferr_out_q;
    assign Overrun_Err = ovr_q;
    assign Busy        = busy_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Self-checking bench for uart_rx_param: an 8-bit/16x instance and a 7-bit/8x
// instance share one bench-driven serial line selected by 'sel'. Expected words
// and flags come from a frame-level model of what the transmitter sent.
`timescale 1ns/1ps
module tb_uart_rx_param;

    typedef struct {
        logic [8:0] d;
        logic       pe;
        logic       fe;
    } rec_t;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic rstn;
    logic line_drv;
    int   sel;

    logic        rx_a, en_a, st_a, ready_a;
    logic [15:0] div_a;
    logic [1:0]  pm_a;
    logic [7:0]  data_a;
    logic        valid_a, pe_a, fe_a, ov_a, busy_a;

    logic        rx_b, en_b, st_b, ready_b;
    logic [15:0] div_b;
    logic [1:0]  pm_b;
    logic [6:0]  data_b;
    logic        valid_b, pe_b, fe_b, ov_b, busy_b;

    assign rx_a = (sel == 0) ? line_drv : 1'b1;
    assign rx_b = (sel == 1) ? line_drv : 1'b1;

    uart_rx_param #(.DATA_W(8), .OVERSAMPLE(16), .DIV_W(16)) dut_a (
        .CLK(clk), .RSTn(rstn), .RX_Pin_In(rx_a), .RX_En_Sig(en_a), .Baud_Div(div_a),
        .Parity_Mode(pm_a), .Stop_Two(st_a), .RX_Data(data_a), .RX_Valid(valid_a),
        .RX_Ready(ready_a), .Parity_Err(pe_a), .Frame_Err(fe_a), .Overrun_Err(ov_a),
        .Busy(busy_a)
    );

    uart_rx_param #(.DATA_W(7), .OVERSAMPLE(8), .DIV_W(16)) dut_b (
        .CLK(clk), .RSTn(rstn), .RX_Pin_In(rx_b), .RX_En_Sig(en_b), .Baud_Div(div_b),
        .Parity_Mode(pm_b), .Stop_Two(st_b), .RX_Data(data_b), .RX_Valid(valid_b),
        .RX_Ready(ready_b), .Parity_Err(pe_b), .Frame_Err(fe_b), .Overrun_Err(ov_b),
        .Busy(busy_b)
    );

    int   n_cmp = 0;
    int   n_err = 0;
    rec_t q_a[$];
    logic [8:0] q_b[$];
    int   vcyc_a = 0, vcyc_b = 0, ovc_a = 0;

    // Record accepted words and count valid/overrun cycles
    always @(negedge clk) begin
        if (valid_a) vcyc_a++;
        if (valid_b) vcyc_b++;
        if (ov_a) ovc_a++;
        if (valid_a && ready_a) q_a.push_back('{d: 9'(data_a), pe: pe_a, fe: fe_a});
        if (valid_b && ready_b) q_b.push_back(9'(data_b));
    end

    // Reference model: word and flags implied by the transmitted frame
    function automatic rec_t model(input int nbits, input logic [8:0] d, input logic [1:0] pm,
                                   input logic pb, input logic two, input logic s1, input logic s2);
        rec_t r;
        int   ones;
        logic par;
        ones = 0;
        r.d  = '0;
        for (int i = 0; i < nbits; i++) begin
            r.d[i] = d[i];
            ones   = ones + int'(d[i]);
        end
        par  = 1'(ones % 2);
        r.pe = (pm == 2'd1) ? (pb != par) : (pm == 2'd2) ? (pb == par) : 1'b0;
        r.fe = !s1 || (two && !s2);
        return r;
    endfunction

    task automatic hold(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic send_frame(input int nbits, input logic [8:0] d, input logic [1:0] pm,
                              input logic pb, input logic two, input logic s1, input logic s2,
                              input int bclk);
        line_drv = 1'b0;
        hold(bclk);
        for (int i = 0; i < nbits; i++) begin
            line_drv = d[i];
            hold(bclk);
        end
        if (pm == 2'd1 || pm == 2'd2) begin
            line_drv = pb;
            hold(bclk);
        end
        line_drv = s1;
        hold(bclk);
        if (two) begin
            line_drv = s2;
            hold(bclk);
        end
        line_drv = 1'b1;
        hold(bclk);
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        hold(3);
        n_cmp++;
        if ({data_a, valid_a, pe_a, fe_a, ov_a, busy_a} !== 13'd0) begin
            n_err++;
            $display("FAIL reset_a: outputs %h expected 0", {data_a, valid_a, pe_a, fe_a, ov_a, busy_a});
        end
        n_cmp++;
        if ({data_b, valid_b, pe_b, fe_b, ov_b, busy_b} !== 12'd0) begin
            n_err++;
            $display("FAIL reset_b: outputs %h expected 0", {data_b, valid_b, pe_b, fe_b, ov_b, busy_b});
        end
        rstn = 1'b1;
        hold(4);
        n_cmp++;
        if (busy_a !== 1'b0) begin
            n_err++;
            $display("FAIL idle_after_reset: Busy %b expected 0", busy_a);
        end
    endtask

    task automatic test_basic_8n1();
        int   v0;
        logic [7:0] words [2];
        words[0] = 8'h55;
        words[1] = 8'hA3;
        sel = 0; div_a = 16'd27; pm_a = 2'd0; st_a = 1'b0; ready_a = 1'b1;
        q_a.delete();
        v0 = vcyc_a;
        for (int k = 0; k < 2; k++) send_frame(8, 9'(words[k]), 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 27 * 16);
        n_cmp++;
        if (q_a.size() != 2 || vcyc_a - v0 != 2) begin
            n_err++;
            $display("FAIL basic_count: words %0d valid cycles %0d expected 2/2", q_a.size(), vcyc_a - v0);
        end
        for (int k = 0; k < 2 && k < q_a.size(); k++) begin
            n_cmp++;
            if (q_a[k].d !== 9'(words[k]) || q_a[k].pe !== 1'b0 || q_a[k].fe !== 1'b0) begin
                n_err++;
                $display("FAIL basic_word%0d: got %h pe %b fe %b expected %h no errors",
                         k, q_a[k].d, q_a[k].pe, q_a[k].fe, words[k]);
            end
        end
    endtask

    task automatic test_parity();
        logic [1:0] pms [3];
        logic       pbs [3];
        rec_t       exp;
        pms[0] = 2'd1; pbs[0] = 1'b1;
        pms[1] = 2'd1; pbs[1] = 1'b0;
        pms[2] = 2'd2; pbs[2] = 1'b1;
        sel = 0; div_a = 16'd4; st_a = 1'b0; ready_a = 1'b1;
        for (int k = 0; k < 3; k++) begin
            pm_a = pms[k];
            q_a.delete();
            send_frame(8, 9'h0A5, pms[k], pbs[k], 1'b0, 1'b1, 1'b1, 64);
            exp = model(8, 9'h0A5, pms[k], pbs[k], 1'b0, 1'b1, 1'b1);
            n_cmp++;
            if (q_a.size() != 1 || q_a[0].d !== exp.d || q_a[0].pe !== exp.pe || q_a[0].fe !== exp.fe) begin
                n_err++;
                $display("FAIL parity_case%0d: words %0d first %h pe %b expected one word %h pe %b",
                         k, q_a.size(), (q_a.size() > 0) ? q_a[0].d : 9'h1FF,
                         (q_a.size() > 0) ? q_a[0].pe : 1'bx, exp.d, exp.pe);
            end
        end
        pm_a = 2'd0;
    endtask

    task automatic test_stop_break();
        sel = 0; div_a = 16'd4; pm_a = 2'd0; st_a = 1'b1; ready_a = 1'b1;
        q_a.delete();
        send_frame(8, 9'h0C7, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 64);
        n_cmp++;
        if (q_a.size() != 1 || q_a[0].d !== 9'h0C7 || q_a[0].fe !== 1'b1 || q_a[0].pe !== 1'b0) begin
            n_err++;
            $display("FAIL stop2_frame: words %0d fe %b expected one word c7 fe 1",
                     q_a.size(), (q_a.size() > 0) ? q_a[0].fe : 1'bx);
        end
        q_a.delete();
        line_drv = 1'b0;
        hold(20 * 64);
        n_cmp++;
        if (busy_a !== 1'b1) begin
            n_err++;
            $display("FAIL break_busy: Busy %b expected 1 while line held low", busy_a);
        end
        line_drv = 1'b1;
        hold(3 * 64);
        n_cmp++;
        if (busy_a !== 1'b0 || q_a.size() != 1) begin
            n_err++;
            $display("FAIL break_release: Busy %b words %0d expected 0 and 1", busy_a, q_a.size());
        end else begin
            n_cmp++;
            if (q_a[0].d !== 9'h000 || q_a[0].fe !== 1'b1) begin
                n_err++;
                $display("FAIL break_word: got %h fe %b expected 000 fe 1", q_a[0].d, q_a[0].fe);
            end
        end
        st_a = 1'b0;
    endtask

    task automatic test_glitch();
        int v0;
        sel = 0; div_a = 16'd4; ready_a = 1'b1;
        q_a.delete();
        v0 = vcyc_a;
        line_drv = 1'b0;
        hold(5 * 4);
        line_drv = 1'b1;
        hold(64);
        n_cmp++;
        if (busy_a !== 1'b0 || q_a.size() != 0 || vcyc_a != v0) begin
            n_err++;
            $display("FAIL glitch: Busy %b words %0d valid cycles %0d expected 0/0/0",
                     busy_a, q_a.size(), vcyc_a - v0);
        end
    endtask

`ifdef UART_RX_MAJORITY_VOTE_EN
    task automatic test_majority_spike();
        sel = 0; div_a = 16'd4; pm_a = 2'd0; st_a = 1'b0; ready_a = 1'b1;
        q_a.delete();
        line_drv = 1'b0;
        hold(64);
        for (int i = 0; i < 8; i++) begin
            line_drv = 1'b1;
            if (i == 3) begin
                hold(31);
                line_drv = 1'b0;
                hold(4);
                line_drv = 1'b1;
                hold(29);
            end else begin
                hold(64);
            end
        end
        line_drv = 1'b1;
        hold(128);
        n_cmp++;
        if (q_a.size() != 1 || q_a[0].d !== 9'h0FF) begin
            n_err++;
            $display("FAIL majority_spike: words %0d first %h expected one word ff",
                     q_a.size(), (q_a.size() > 0) ? q_a[0].d : 9'h1FF);
        end
    endtask
`endif

    task automatic test_overrun();
        int o0;
        sel = 0; div_a = 16'd4; pm_a = 2'd0; st_a = 1'b0; ready_a = 1'b0;
        q_a.delete();
        o0 = ovc_a;
        send_frame(8, 9'h011, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 64);
        send_frame(8, 9'h022, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 64);
        n_cmp++;
        if (data_a !== 8'h11 || valid_a !== 1'b1 || ovc_a - o0 != 1) begin
            n_err++;
            $display("FAIL overrun_hold: data %h valid %b overrun pulses %0d expected 11/1/1",
                     data_a, valid_a, ovc_a - o0);
        end
        ready_a = 1'b1;
        hold(1);
        n_cmp++;
        if (valid_a !== 1'b0 || q_a.size() != 1) begin
            n_err++;
            $display("FAIL overrun_drain: valid %b accepted %0d expected 0 and 1", valid_a, q_a.size());
        end
    endtask

    task automatic test_abort();
        sel = 0; div_a = 16'd4; pm_a = 2'd0; st_a = 1'b0; ready_a = 1'b1;
        // reset in the middle of the data bits
        line_drv = 1'b0;
        hold(64);
        line_drv = 1'b1;
        hold(96);
        n_cmp++;
        if (busy_a !== 1'b1) begin
            n_err++;
            $display("FAIL abort_mid_busy: Busy %b expected 1", busy_a);
        end
        rstn = 1'b0;
        hold(2);
        n_cmp++;
        if ({data_a, valid_a, pe_a, fe_a, ov_a, busy_a} !== 13'd0) begin
            n_err++;
            $display("FAIL abort_reset_values: outputs %h expected 0", {data_a, valid_a, pe_a, fe_a, ov_a, busy_a});
        end
        rstn = 1'b1;
        hold(64);
        // receiver disabled in the middle of a frame
        q_a.delete();
        line_drv = 1'b0;
        hold(3 * 64);
        en_a = 1'b0;
        line_drv = 1'b1;
        hold(2);
        n_cmp++;
        if (busy_a !== 1'b0) begin
            n_err++;
            $display("FAIL abort_enable_busy: Busy %b expected 0", busy_a);
        end
        en_a = 1'b1;
        hold(3 * 64);
        n_cmp++;
        if (q_a.size() != 0 || valid_a !== 1'b0) begin
            n_err++;
            $display("FAIL abort_no_word: words %0d valid %b expected 0/0", q_a.size(), valid_a);
        end
        send_frame(8, 9'h03C, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 64);
        n_cmp++;
        if (q_a.size() != 1 || q_a[0].d !== 9'h03C || q_a[0].fe !== 1'b0) begin
            n_err++;
            $display("FAIL abort_recover: words %0d first %h expected one word 3c",
                     q_a.size(), (q_a.size() > 0) ? q_a[0].d : 9'h1FF);
        end
    endtask

    task automatic test_random();
        logic [8:0] d;
        logic [1:0] pm;
        logic       two, pb, s1, s2;
        int         dv, bclk;
        rec_t       exp;
        sel = 0; ready_a = 1'b1;
        for (int k = 0; k < 10; k++) begin
            d   = 9'($urandom);
            pm  = 2'($urandom);
            two = 1'($urandom);
            pb  = 1'($urandom);
            s1  = ($urandom_range(0, 3) != 0);
            s2  = ($urandom_range(0, 3) != 0);
            dv  = $urandom_range(0, 5);
            div_a = 16'(dv); pm_a = pm; st_a = two;
            bclk = ((dv == 0) ? 1 : dv) * 16;
            hold(4);
            q_a.delete();
            send_frame(8, d, pm, pb, two, s1, s2, bclk);
            exp = model(8, d, pm, pb, two, s1, s2);
            n_cmp++;
            if (q_a.size() != 1 || q_a[0].d !== exp.d || q_a[0].pe !== exp.pe || q_a[0].fe !== exp.fe) begin
                n_err++;
                $display("FAIL random%0d: words %0d got %h pe %b fe %b expected %h pe %b fe %b (pm %0d two %b div %0d)",
                         k, q_a.size(), (q_a.size() > 0) ? q_a[0].d : 9'h1FF,
                         (q_a.size() > 0) ? q_a[0].pe : 1'bx, (q_a.size() > 0) ? q_a[0].fe : 1'bx,
                         exp.d, exp.pe, exp.fe, pm, two, dv);
            end
        end
        pm_a = 2'd0; st_a = 1'b0;
    endtask

    task automatic test_small_cfg();
        int         v0;
        logic [8:0] words [2];
        words[0] = 9'h055;
        words[1] = 9'h0A3;
        sel = 1; div_b = 16'd27; pm_b = 2'd0; st_b = 1'b0; ready_b = 1'b1;
        q_b.delete();
        v0 = vcyc_b;
        for (int k = 0; k < 2; k++) send_frame(7, words[k], 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 27 * 8);
        n_cmp++;
        if (q_b.size() != 2 || vcyc_b - v0 != 2) begin
            n_err++;
            $display("FAIL small_count: words %0d valid cycles %0d expected 2/2", q_b.size(), vcyc_b - v0);
        end
        for (int k = 0; k < 2 && k < q_b.size(); k++) begin
            n_cmp++;
            if (q_b[k] !== model(7, words[k], 2'd0, 1'b0, 1'b0, 1'b1, 1'b1).d) begin
                n_err++;
                $display("FAIL small_word%0d: got %h expected %h", k, q_b[k],
                         model(7, words[k], 2'd0, 1'b0, 1'b0, 1'b1, 1'b1).d);
            end
        end
        sel = 0;
    endtask

    // Bound on total run time
    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        sel = 0; line_drv = 1'b1; rstn = 1'b0;
        en_a = 1'b1; st_a = 1'b0; ready_a = 1'b1; div_a = 16'd4; pm_a = 2'd0;
        en_b = 1'b1; st_b = 1'b0; ready_b = 1'b1; div_b = 16'd4; pm_b = 2'd0;
        test_reset();
        test_basic_8n1();
        test_parity();
        test_stop_break();
        test_glitch();
`ifdef UART_RX_MAJORITY_VOTE_EN
        test_majority_spike();
`endif
        test_overrun();
        test_abort();
        test_random();
        test_small_cfg();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
- Parametrised UART receiver, successor to the fixed 8N1 RX controller.
- Contains its own oversampling baud prescaler, so no external BPS_CLK or H2L detector is needed.
- Supports runtime-selectable parity and 1/2 stop bits, validated start detection, and error flags.
- Delivers each word over a valid/ready handshake to the downstream command parser / FIFO in the UART interface.

Parameters:
DATA_W, 8, data bits per frame (5..9), LSB first
OVERSAMPLE, 16, ticks per bit (even, 8..32)
DIV_W, 16, width of Baud_Div

Ports:
CLK  in  1  system clock
RSTn  in  1  async active-low reset
RX_Pin_In  in  1  asynchronous serial line, idle high
RX_En_Sig  in  1  receiver enable
Baud_Div  in  DIV_W  CLK cycles per oversample tick; 0 treated as 1
Parity_Mode  in  2  0 none, 1 even, 2 odd, 3 none
Stop_Two  in  1  1 = two stop bits checked
RX_Data  out  DATA_W  received word
RX_Valid  out  1  RX_Data/flags valid
RX_Ready  in  1  consumer accepts when RX_Valid&&RX_Ready
Parity_Err  out  1  qualifies current RX_Data
Frame_Err  out  1  qualifies current RX_Data
Overrun_Err  out  1  one-cycle pulse, completed frame dropped
Busy  out  1  state != IDLE

Behaviour:
- Clock and reset: one clock CLK; reset RSTn is asynchronous, active-low.
- Reset values: all outputs 0, state IDLE, prescaler and tick counter 0, synchroniser flops 1.
- Input sync: RX_Pin_In passes through a 2-flop synchroniser; all logic uses the synchronised line.
- Prescaler: counts 0..max(Baud_Div,1)-1 and pulses tick on wrap.
- Tick counter: counts 0..OVERSAMPLE-1 on each tick.
- IDLE:
  - Runs only when RX_En_Sig=1.
  - A falling edge on the synced line clears the prescaler and tick counter, then moves to START.
- START:
  - At tick count OVERSAMPLE/2-1, sample the line.
  - If high (glitch): return to IDLE, no output.
  - If low: clear the tick counter and go to DATA with bit index 0.
- Bit sampling:
  - Every subsequent bit is sampled when tick count = OVERSAMPLE-1 (bit centre).
  - The tick counter then wraps to 0.
- DATA: shift the sample into bit[index]. After index DATA_W-1 go to PARITY if Parity_Mode is 1 or 2, else STOP1.
- PARITY:
  - Compare the sample with the XOR of the data bits (even), or its inverse (odd).
  - On mismatch, set the internal perr.
- STOP1: a sample of 0 sets ferr. Go to STOP2 if Stop_Two, else DONE.
- STOP2: same check as STOP1, then DONE.
- DONE (one cycle):
  - If RX_Valid=0, or RX_Valid=1 with RX_Ready=1 in this cycle: load RX_Data, Parity_Err and Frame_Err, and set RX_Valid.
  - Otherwise keep the old word and pulse Overrun_Err.
  - If ferr and the line is still low (break): go to BREAK, else IDLE.
- BREAK: wait for the line to be high, then go to IDLE.
- Latency: RX_Valid rises 2 CLK after the last stop-bit sample clock edge (state reaches DONE, registers load).
- Handshake:
  - RX_Valid stays high until RX_Valid&&RX_Ready.
  - It clears the next cycle unless DONE loads a new word in the same cycle, in which case it stays 1 with new data.
  - RX_Data and the flags are stable while RX_Valid=1.
- RX_En_Sig=0 mid-frame: abort to IDLE next clock with no output; the pending RX_Valid word is kept.
- Config changes: Baud_Div, Parity_Mode and Stop_Two are sampled continuously and must only change while Busy=0.
- DATA_W=9 with parity: parity covers all 9 bits.

Optional Feature:
- Macro: UART_RX_MAJORITY_VOTE_EN.
- Defined: each data/parity/stop bit value is the 2-of-3 majority of samples at tick counts OVERSAMPLE-3, OVERSAMPLE-2 and OVERSAMPLE-1. The START check uses the majority at OVERSAMPLE/2-3..OVERSAMPLE/2-1.
- Undefined: single sample as described above.
- The sampling instant and latency are identical either way.

Decomposition:
- Package uart_pkg:
  - State enum (IDLE, START, DATA, PARITY, STOP1, STOP2, DONE, BREAK).
  - Parity_Mode constants PAR_NONE=0, PAR_EVEN=1, PAR_ODD=2.
- Sub-module uart_baud_tick holds the prescaler and tick counter, with clear input, tick and tick-count outputs.
  - It is reused by the planned parametrised TX.

Test Plan:
- 50 MHz CLK, Baud_Div=27, 8N1, send 0x55 then 0xA3 with RX_Ready=1 -> RX_Data 0x55 then 0xA3, one RX_Valid cycle each, no errors.
- Parity_Mode=1, send 0xA5 with parity bit 1 (wrong) -> RX_Data=0xA5, Parity_Err=1. Repeat with parity bit 0 -> Parity_Err=0. Repeat with Parity_Mode=2 and parity bit 1 -> Parity_Err=0.
- Stop_Two=1, second stop bit 0 -> Frame_Err=1. Then hold the line low 20 bit times -> single word 0x00 with Frame_Err, Busy until the line returns high, no further words.
- Low glitch of 5 ticks (< OVERSAMPLE/2) -> no RX_Valid, Busy back to 0 within 1 bit time. With the macro defined, a 1-tick low spike mid data bit does not flip that bit.
- RX_Ready=0, send two frames 0x11 and 0x22 -> RX_Data stays 0x11, Overrun_Err pulses once. Then RX_Ready=1 -> RX_Valid drops.
- RSTn low mid-DATA or RX_En_Sig low mid-frame -> IDLE, no word, outputs at reset values (reset case). A following clean frame 0x3C is received correctly. Repeat the first test with DATA_W=7 and OVERSAMPLE=8.
